aes_round_seq: RTL and testbench

AES_ROUND_SEQ -- requirements
Module: aes_round_seq

---
 rtl/aes_round_seq.sv | 149 ++++++++++++++
 tb/tb_aes_round_seq.sv | 383 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/aes_round_seq.sv
// aes_round_seq: iterative AES-128 round sequencer.
// Holds the cipher state and the current round key. One round is applied per
// clock using an external combinational round datapath (rnd_result) and an
// external key expander (key_next). Output is registered and held until the
// next block completes.
// Optional feature: define AES_SEQ_ABORT_EN to add an 'abort' input that
// cancels a block while it is running.
//
// Handshake: a transfer happens on a rising edge where valid and ready are
// both 1. in_ready is 1 only in IDLE and out_valid is 1 only in DONE, so the
// two are never high together. Once out_valid is raised, it stays high and
// out_data stays stable until out_ready is sampled high.
module aes_round_seq #(
  parameter int NR = 10
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_data,
  input  logic [127:0] in_key,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_data,
  output logic [127:0] rnd_state,
  output logic [127:0] rnd_key,
  output logic [3:0]   rnd_index,
  output logic         rnd_last,
  input  logic [127:0] rnd_result,
  input  logic [127:0] key_next,
`ifdef AES_SEQ_ABORT_EN
  input  logic         abort,
`endif
  output logic [1:0]   fsm_state
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [3:0] LAST_ROUND = 4'(NR);

  state_t       state;
  state_t       state_next;
  logic [3:0]   round;
  logic [127:0] state_reg;
  logic [127:0] key_reg;
  logic [127:0] out_reg;
  logic [127:0] round_out;
  logic         abort_hit;

  // Result of the round currently being applied: datapath output plus next key.
  assign round_out = rnd_result ^ key_next;

`ifdef AES_SEQ_ABORT_EN
  // Abort only has an effect while a block is in flight.
  assign abort_hit = abort && (state == RUN);
`else
  assign abort_hit = 1'b0;
`endif

  // Register outputs go straight to the datapath: no input reaches them combinationally.
  assign rnd_state = state_reg;
  assign rnd_key   = key_reg;
  assign out_data  = out_reg;
  assign fsm_state = state;

  // FSM state register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic and state-decoded handshake/round outputs.
  always_comb begin
    state_next = state;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    rnd_index  = 4'd0;
    rnd_last   = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_next = RUN;
      end
      RUN: begin
        rnd_index = round;
        rnd_last  = (round == LAST_ROUND);
        if (abort_hit) begin
          state_next = IDLE;
        end else if (round == LAST_ROUND) begin
          state_next = DONE;
        end
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Round counter, cipher state, round key and result registers.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      round     <= 4'd0;
      state_reg <= 128'd0;
      key_reg   <= 128'd0;
      out_reg   <= 128'd0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            // Round-0 AddRoundKey happens on acceptance.
            state_reg <= in_data ^ in_key;
            key_reg   <= in_key;
            round     <= 4'd1;
          end
        end
        RUN: begin
          if (abort_hit) begin
            round     <= 4'd0;
            state_reg <= 128'd0;
            key_reg   <= 128'd0;
          end else begin
            state_reg <= round_out;
            key_reg   <= key_next;
            if (round == LAST_ROUND) begin
              out_reg <= round_out;
            end else begin
              round <= round + 4'd1;
            end
          end
        end
        default: begin
          // DONE holds everything until the consumer takes the result.
        end
      endcase
    end
  end

endmodule

// File: tb/tb_aes_round_seq.sv
// tb_aes_round_seq: bench for aes_round_seq with a standard AES-128 round
// datapath and key expander attached, plus a reference encryptor.
module tb_aes_round_seq;

  logic         clock;
  logic         reset;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] in_data;
  logic [127:0] in_key;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] out_data;
  logic [127:0] rnd_state;
  logic [127:0] rnd_key;
  logic [3:0]   rnd_index;
  logic         rnd_last;
  logic [127:0] rnd_result;
  logic [127:0] key_next;
  logic [1:0]   fsm_state;
`ifdef AES_SEQ_ABORT_EN
  logic         abort;
`endif

  int n_cmp = 0;
  int n_bad = 0;
  logic [127:0] exp_q[$];
  logic         prev_valid = 1'b0;
  time          done_time = 0;

  aes_round_seq #(.NR(10)) dut (
    .clock      (clock),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .in_key     (in_key),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .rnd_state  (rnd_state),
    .rnd_key    (rnd_key),
    .rnd_index  (rnd_index),
    .rnd_last   (rnd_last),
    .rnd_result (rnd_result),
    .key_next   (key_next),
`ifdef AES_SEQ_ABORT_EN
    .abort      (abort),
`endif
    .fsm_state  (fsm_state)
  );

  // ---------------- clock ----------------
  initial clock = 1'b0;
  always #5 clock = ~clock;

  // ---------------- AES helpers ----------------
  function automatic logic [7:0] xt(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    logic [7:0] x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xt(x);
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
    logic [7:0] r = b;
    for (int i = 0; i < n; i++) r = {r[6:0], r[7]};
    return r;
  endfunction

  // S-box from the multiplicative inverse (x^254) and the affine transform.
  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [7:0] inv = 8'h01;
    logic [7:0] e = 8'd254;
    for (int i = 7; i >= 0; i--) begin
      inv = gmul(inv, inv);
      if (e[i]) inv = gmul(inv, x);
    end
    return inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
  endfunction

  function automatic logic [7:0] gb(input logic [127:0] s, input int i);
    return s[127-8*i -: 8];
  endfunction

  function automatic logic [127:0] round_fn(input logic [127:0] s, input logic last);
    logic [127:0] ss;
    logic [127:0] m;
    logic [7:0] a0, a1, a2, a3;
    ss = '0;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        ss[127-8*(r+4*c) -: 8] = sbox(gb(s, r + 4*((c+r)%4)));
    if (last) return ss;
    m = '0;
    for (int c = 0; c < 4; c++) begin
      a0 = gb(ss, 4*c); a1 = gb(ss, 4*c+1); a2 = gb(ss, 4*c+2); a3 = gb(ss, 4*c+3);
      m[127-8*(4*c)   -: 8] = xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3;
      m[127-8*(4*c+1) -: 8] = a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3;
      m[127-8*(4*c+2) -: 8] = a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3;
      m[127-8*(4*c+3) -: 8] = xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3);
    end
    return m;
  endfunction

  function automatic logic [7:0] rcon(input logic [3:0] idx);
    case (idx)
      4'd1: return 8'h01;  4'd2: return 8'h02;  4'd3: return 8'h04;
      4'd4: return 8'h08;  4'd5: return 8'h10;  4'd6: return 8'h20;
      4'd7: return 8'h40;  4'd8: return 8'h80;  4'd9: return 8'h1b;
      4'd10: return 8'h36;
      default: return 8'h00;
    endcase
  endfunction

  function automatic logic [127:0] key_exp(input logic [127:0] k, input logic [3:0] idx);
    logic [31:0] w0, w1, w2, w3, t, n0, n1, n2, n3;
    w0 = k[127:96]; w1 = k[95:64]; w2 = k[63:32]; w3 = k[31:0];
    t = {sbox(w3[23:16]), sbox(w3[15:8]), sbox(w3[7:0]), sbox(w3[31:24])} ^ {rcon(idx), 24'h0};
    n0 = w0 ^ t; n1 = w1 ^ n0; n2 = w2 ^ n1; n3 = w3 ^ n2;
    return {n0, n1, n2, n3};
  endfunction

  function automatic logic [127:0] aes_ref(input logic [127:0] pt, input logic [127:0] key);
    logic [127:0] s = pt ^ key;
    logic [127:0] k = key;
    for (int r = 1; r <= 10; r++) begin
      k = key_exp(k, 4'(r));
      s = round_fn(s, r == 10) ^ k;
    end
    return s;
  endfunction

  // External round datapath and key expander.
  always_comb begin
    rnd_result = round_fn(rnd_state, rnd_last);
    key_next   = key_exp(rnd_key, rnd_index);
  end

  // ---------------- checking ----------------
  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    n_cmp++;
    n_bad++;
    $display("FAIL %s: got timeout expected event", name);
  endtask

  // Scoreboard: pop one expected ciphertext on each rising out_valid.
  always @(negedge clock) begin
    if (out_valid && !prev_valid) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_out: got %h expected no output", out_data);
      end else begin
        check("out_data", out_data, exp_q.pop_front());
      end
      done_time = $time - 5;
    end
    if (in_ready && out_valid) begin
      n_cmp++;
      n_bad++;
      $display("FAIL ready_valid_overlap: got 1 expected 0");
    end
    prev_valid = out_valid;
  end

  // ---------------- driver tasks ----------------
  // Presents a block and returns the time of its accept edge; leaves in_valid high.
  task automatic send_block(input logic [127:0] pt, input logic [127:0] key, output time acc);
    int budget = 0;
    in_data  = pt;
    in_key   = key;
    in_valid = 1'b1;
    while (!in_ready && budget < 100) begin
      @(negedge clock);
      budget++;
    end
    if (!in_ready) begin
      fail_now("accept");
      acc = 0;
      return;
    end
    exp_q.push_back(aes_ref(pt, key));
    @(posedge clock);
    acc = $time;
    #1;
  endtask

  task automatic wait_done();
    int budget = 0;
    while (exp_q.size() != 0 && budget < 100) begin
      @(negedge clock);
      budget++;
    end
    if (exp_q.size() != 0) begin
      fail_now("completion");
      exp_q.delete();
    end
    @(negedge clock);
  endtask

  task automatic wait_index(input logic [3:0] idx);
    int budget = 0;
    @(negedge clock);
    while (rnd_index != idx && budget < 50) begin
      @(negedge clock);
      budget++;
    end
    if (rnd_index != idx) fail_now("wait_index");
  endtask

  // ---------------- vectors ----------------
  typedef struct {
    logic [127:0] pt;
    logic [127:0] key;
    logic [127:0] ct;
  } vec_t;

  localparam logic [127:0] FIPS_KEY = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] FIPS_PT  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] FIPS_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

  // ---------------- main sequence ----------------
  initial begin
    vec_t vecs[6];
    time t_acc, t_acc2, t_rel;
    logic [127:0] pt, key, ct, last_ct;

    reset     = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    in_key    = '0;
    out_ready = 1'b1;
`ifdef AES_SEQ_ABORT_EN
    abort     = 1'b0;
`endif

    vecs[0] = '{FIPS_PT, FIPS_KEY, FIPS_CT};
    vecs[1] = '{128'h3243f6a8885a308d313198a2e0370734,
                128'h2b7e151628aed2a6abf7158809cf4f3c,
                128'h3925841d02dc09fbdc118597196a0b32};
    for (int i = 2; i < 6; i++) begin
      vecs[i].pt  = {$urandom, $urandom, $urandom, $urandom};
      vecs[i].key = {$urandom, $urandom, $urandom, $urandom};
      vecs[i].ct  = aes_ref(vecs[i].pt, vecs[i].key);
    end

    // Reset state after release.
    repeat (3) @(negedge clock);
    reset = 1'b0;
    #1;
    check("rst_in_ready", 128'(in_ready), 128'd1);
    check("rst_out_valid", 128'(out_valid), 128'd0);
    check("rst_rnd_index", 128'(rnd_index), 128'd0);
    check("rst_rnd_last", 128'(rnd_last), 128'd0);
    check("rst_out_data", out_data, 128'd0);
    check("rst_rnd_state", rnd_state, 128'd0);
    check("rst_rnd_key", rnd_key, 128'd0);
    @(negedge clock);

    // FIPS-197 vector with round-index sequence and latency.
    send_block(FIPS_PT, FIPS_KEY, t_acc);
    in_valid = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clock);
      if (k == 1) check("accept_state", rnd_state, FIPS_PT ^ FIPS_KEY);
      check("rnd_index", 128'(rnd_index), 128'(k));
      check("rnd_last", 128'(rnd_last), 128'(k == 10));
      check("run_in_ready", 128'(in_ready), 128'd0);
      check("run_out_valid", 128'(out_valid), 128'd0);
    end
    wait_done();
    check("latency", 128'((done_time - t_acc) / 10), 128'd10);
    check("fips_hold", out_data, FIPS_CT);

    // Table of known-answer and random vectors.
    for (int i = 0; i < 6; i++) begin
      send_block(vecs[i].pt, vecs[i].key, t_acc);
      in_valid = 1'b0;
      wait_done();
      check("vec_out_data", out_data, vecs[i].ct);
    end

    // Stall in DONE for 5 cycles.
    out_ready = 1'b0;
    pt = vecs[3].pt ^ 128'h1;
    key = vecs[4].key;
    ct = aes_ref(pt, key);
    send_block(pt, key, t_acc);
    in_valid = 1'b0;
    begin
      int budget = 0;
      @(negedge clock);
      while (!out_valid && budget < 50) begin
        @(negedge clock);
        budget++;
      end
      if (!out_valid) fail_now("stall_valid");
    end
    for (int i = 0; i < 5; i++) begin
      check("stall_valid", 128'(out_valid), 128'd1);
      check("stall_data", out_data, ct);
      if (i < 4) @(negedge clock);
    end
    out_ready = 1'b1;
    @(negedge clock);
    check("release_valid", 128'(out_valid), 128'd0);
    check("release_ready", 128'(in_ready), 128'd1);
    check("release_data", out_data, ct);

    // Back-to-back with in_valid held high.
    send_block(vecs[2].pt, vecs[2].key, t_acc);
    send_block(vecs[5].pt, vecs[5].key, t_acc2);
    in_valid = 1'b0;
    check("b2b_period", 128'((t_acc2 - t_acc) / 10), 128'd12);
    wait_done();
    last_ct = vecs[5].ct;

    // Reset at round 5 discards the block.
    send_block(vecs[1].pt, vecs[1].key, t_acc);
    in_valid = 1'b0;
    wait_index(4'd5);
    reset = 1'b1;
    #1;
    exp_q.delete();
    check("rst5_out_valid", 128'(out_valid), 128'd0);
    check("rst5_rnd_index", 128'(rnd_index), 128'd0);
    check("rst5_rnd_last", 128'(rnd_last), 128'd0);
    check("rst5_rnd_state", rnd_state, 128'd0);
    check("rst5_rnd_key", rnd_key, 128'd0);
    check("rst5_out_data", out_data, 128'd0);
    repeat (2) @(negedge clock);
    reset = 1'b0;
    t_rel = $time;
    send_block(vecs[0].pt, vecs[0].key, t_acc);
    in_valid = 1'b0;
    check("first_accept", 128'(t_acc - t_rel), 128'd5);
    wait_done();
    check("post_reset_data", out_data, vecs[0].ct);
    last_ct = vecs[0].ct;
    repeat (15) @(negedge clock);

`ifdef AES_SEQ_ABORT_EN
    // Abort at round 3.
    send_block(vecs[3].pt, vecs[3].key, t_acc);
    in_valid = 1'b0;
    wait_index(4'd3);
    abort = 1'b1;
    @(negedge clock);
    abort = 1'b0;
    exp_q.delete();
    check("abort_ready", 128'(in_ready), 128'd1);
    check("abort_valid", 128'(out_valid), 128'd0);
    check("abort_data", out_data, last_ct);
    check("abort_state", rnd_state, 128'd0);
    check("abort_key", rnd_key, 128'd0);
    repeat (12) @(negedge clock);
    send_block(vecs[4].pt, vecs[4].key, t_acc);
    in_valid = 1'b0;
    wait_done();
    check("post_abort_data", out_data, vecs[4].ct);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
